// File: rtl/predictor_port_arbiter.sv
// Shares the local branch predictor port between fetch lookups and buffered commit updates.
// Define PRED_ARB_STATS_EN to add the stat_lookups/stat_updates/stat_forced counters.
module predictor_port_arbiter #(
  parameter int unsigned LOCAL_WIDTH  = 10,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic                   lk_valid,
  input  logic [31:0]            lk_addr,
  output logic                   lk_ready,
  output logic                   pred_valid,
  output logic                   pred_taken,
  input  logic                   up_valid,
  input  logic [31:0]            up_addr,
  input  logic                   up_taken,
  output logic                   up_ready,
`ifdef PRED_ARB_STATS_EN
  output logic [31:0]            stat_lookups,
  output logic [31:0]            stat_updates,
  output logic [31:0]            stat_forced,
`endif
  output logic [LOCAL_WIDTH-1:0] prd_addr,
  output logic                   prd_transition,
  output logic                   prd_branch,
  input  logic                   prd_prediction
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StW  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {GntIdle, GntLookup, GntUpdate} gnt_e;

  logic [LOCAL_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
  logic                   mem_taken_q [FIFO_DEPTH];
  logic [PtrW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [StW-1:0]         starve_q, starve_d;
  logic                   pend_q, pend_d;
  logic [LOCAL_WIDTH-1:0] prd_addr_q;
  logic                   full, push, pop;
  gnt_e                   gnt;

  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign up_ready = !full && rdy_in;
  assign push     = up_valid && up_ready;
  assign pop      = (gnt == GntUpdate);

  // Reset gates the grant so lk_ready reads 0 while rst_in is held low.
  always_comb begin
    gnt = GntIdle;
    if (rst_in && rdy_in && !flush_in) begin
      if ((count_q != '0) && (!lk_valid || full || (starve_q == StW'(STARVE_LIMIT)))) begin
        gnt = GntUpdate;
      end else if (lk_valid) begin
        gnt = GntLookup;
      end
    end
  end

  always_comb begin
    lk_ready       = (gnt == GntLookup);
    prd_transition = (gnt == GntUpdate);
    prd_branch     = 1'b0;
    prd_addr       = prd_addr_q;
    unique case (gnt)
      GntUpdate: begin
        prd_addr   = mem_addr_q[head_q];
        prd_branch = mem_taken_q[head_q];
      end
      GntLookup: prd_addr = lk_addr[LOCAL_WIDTH+1:2];
      default:   prd_addr = prd_addr_q;
    endcase
  end

  // The predictor registers its index, so its output belongs to last cycle's lookup.
  assign pred_valid = pend_q && !flush_in;
  assign pred_taken = pred_valid && prd_prediction;

  always_comb begin
    head_d   = pop  ? head_q + PtrW'(1) : head_q;
    tail_d   = push ? tail_q + PtrW'(1) : tail_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CntW'(1);
    if (pop && !push) count_d = count_q - CntW'(1);
    pend_d   = (gnt == GntLookup);
    starve_d = starve_q;
    if (flush_in || gnt == GntUpdate) begin
      starve_d = '0;
    end else if (gnt == GntLookup) begin
      if (count_q == '0) begin
        starve_d = '0;
      end else if (starve_q != StW'(STARVE_LIMIT)) begin
        starve_d = starve_q + StW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      pend_q     <= 1'b0;
      prd_addr_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      pend_q     <= pend_d;
      prd_addr_q <= prd_addr;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_addr_q[tail_q]  <= up_addr[LOCAL_WIDTH+1:2];
      mem_taken_q[tail_q] <= up_taken;
    end
  end

`ifdef PRED_ARB_STATS_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stat_lookups <= '0;
      stat_updates <= '0;
      stat_forced  <= '0;
    end else begin
      if (gnt == GntLookup) stat_lookups <= stat_lookups + 32'd1;
      if (gnt == GntUpdate) stat_updates <= stat_updates + 32'd1;
      // With lk_valid high, an update only wins through starvation or a full FIFO.
      if (gnt == GntUpdate && lk_valid) stat_forced <= stat_forced + 32'd1;
    end
  end
`endif

endmodule

// File: doc/predictor_port_arbiter.md
Name: predictor_port_arbiter

Overview:
- Shares the single address/update port of the local branch predictor between fetch-side lookups and commit-side outcome updates.
- Buffers committed branch outcomes in a small FIFO.
- Grants one predictor access per cycle, and returns the lookup result one cycle after grant.
- Sits between the IFetch/ROB commit logic and the predictor instance.

Parameters:
LOCAL_WIDTH, 10, predictor index width; predictor address bits [LOCAL_WIDTH+1:2]
FIFO_DEPTH, 4, pending-update FIFO entries; power of two, minimum 2
STARVE_LIMIT, 3, consecutive cycles an update may be deferred by lookups before it is forced

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global ready; all grants paused when low
flush_in  input  1  pipeline flush; cancels in-flight lookup result
lk_valid  input  1  fetch lookup request
lk_addr  input  32  instruction address of lookup
lk_ready  output  1  lookup granted this cycle
pred_valid  output  1  lookup result valid (registered)
pred_taken  output  1  predicted direction, 1 = jump
up_valid  input  1  committed branch outcome
up_addr  input  32  address of committed branch
up_taken  input  1  actual direction, 1 = jump
up_ready  output  1  FIFO can accept an outcome
prd_addr  output  LOCAL_WIDTH  to predictor instr_addr = selected addr[LOCAL_WIDTH+1:2]
prd_transition  output  1  to predictor transition_signal
prd_branch  output  1  to predictor branch
prd_prediction  input  1  from predictor prediction

Behaviour:
- Reset (rst_in low, async): FIFO empty (head = tail = 0, count = 0), starve_cnt = 0, pend = 0, pred_valid = 0, pred_taken = 0, up_ready = 1, lk_ready = 0, prd_transition = 0, prd_branch = 0, prd_addr = 0.
- up_ready = (count != FIFO_DEPTH) & rdy_in.
- No bypass: push when up_valid & up_ready, at the tail. An outcome written into an empty FIFO is issuable no earlier than the next cycle.
- Grant decision, combinational, evaluated only when rdy_in = 1 and flush_in = 0:
  - UPDATE if count != 0 and any of: lk_valid = 0; count == FIFO_DEPTH; starve_cnt == STARVE_LIMIT.
  - Otherwise LOOKUP if lk_valid.
  - Otherwise IDLE.
- UPDATE:
  - prd_addr = head.addr[LOCAL_WIDTH+1:2], prd_transition = 1, prd_branch = head.taken.
  - Pop at clock edge; starve_cnt <= 0.
- LOOKUP:
  - lk_ready = 1, prd_addr = lk_addr[LOCAL_WIDTH+1:2], prd_transition = 0.
  - pend <= 1.
  - starve_cnt <= starve_cnt + 1 if count != 0, else 0. Saturates at STARVE_LIMIT.
- IDLE, or rdy_in = 0: lk_ready = 0, prd_transition = 0, prd_addr holds its last value, FIFO and starve_cnt unchanged.
- Simultaneous push and pop: both happen. count is unchanged, pointers wrap modulo FIFO_DEPTH. up_ready is computed from the pre-edge count, so a full FIFO rejects the push even while popping.
- Lookup latency: one cycle.
  - The cycle after a LOOKUP grant: pred_valid = 1, pred_taken = prd_prediction. The predictor index is registered, so this is independent of rdy_in.
  - pred_valid is a single-cycle pulse per grant; back-to-back grants give back-to-back pulses.
- flush_in = 1:
  - lk_ready = 0 and no grant of any kind.
  - Clears pend, so no pred_valid next cycle; starve_cnt <= 0.
  - FIFO contents are kept (committed outcomes are never dropped); pushes are still accepted.
- flush_in together with rdy_in = 0: flush still clears pend and starve_cnt.
- Mid-operation reset: immediate return to reset values; queued outcomes are lost.

Optional Feature:
- Macro PRED_ARB_STATS_EN. When defined, three additional outputs exist, each 32-bit, wrapping, reset to 0:
  - stat_lookups: +1 per LOOKUP grant.
  - stat_updates: +1 per UPDATE grant.
  - stat_forced: +1 per UPDATE grant caused only by starvation or a full FIFO while lk_valid = 1.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, lk_valid = 1, lk_addr = 0x104, FIFO empty, prd_prediction = 1:
  - Same cycle: lk_ready = 1, prd_addr = 0x041.
  - Next cycle: pred_valid = 1, pred_taken = 1.
- Push 1 outcome (addr 0x200, taken = 1) while lk_valid is held at 1 (default STARVE_LIMIT = 3):
  - Cycles 1–3 after push: LOOKUP.
  - Cycle 4: UPDATE with prd_transition = 1, prd_branch = 1, prd_addr = 0x080, lk_ready = 0.
- Push 4 outcomes with lk_valid = 0 each cycle: each drains one cycle after its push.
- Fill the FIFO to 4 with lk_valid = 1:
  - up_ready = 0.
  - UPDATE forced the following cycle.
  - Push attempted during that pop is rejected; count goes 4 -> 3.
- LOOKUP grant, then flush_in = 1 the next cycle: no pred_valid pulse, no grant, FIFO count unchanged.
- rdy_in = 0 for 5 cycles with 2 queued outcomes and lk_valid = 1:
  - No grants, prd_transition = 0, count stays 2.
  - On rdy_in = 1, normal arbitration resumes.
  - Assert rst_in low mid-run: all outputs return to reset values immediately.
